hlsm_dispatch: RTL
==================

# hlsm_dispatch

Operand-feed and result-capture controller sitting directly in front of the generated HLSM datapath. It accepts operand tuples (a, b, c) on a valid/ready stream, holds them stable on the HLSM inputs, drives the level-sensitive Start for exactly the duration of one HLSM run, and detects completion from Done. It then returns the captured results (z, x) on a valid/ready output stream. One job is in flight at a time.

## Interface
Parameters:
- DATA_W, 32: operand/result width, two's-complement signed.
- TIMEOUT_CYC, 64: maximum RUN cycles before abort; used only with HLSM_TIMEOUT_EN; must be ≥ 16.

Ports:
- Clk  in  1  single clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand tuple valid.
- in_ready  out  1  dispatcher can accept a tuple.
- in_a, in_b, in_c  in  DATA_W  operands.
- Start  out  1  HLSM start/advance level.
- a, b, c  out  DATA_W  registered operands to HLSM.
- Done  in  1  HLSM completion level.
- z, x  in  DATA_W  HLSM results.
- out_valid  out  1  result tuple valid.
- out_ready  in  1  downstream accepts result.
- out_z, out_x  out  DATA_W  captured results.
- busy  out  1  high in RUN or HOLD.
- timeout_err  out  1  sticky abort flag (0 when feature compiled out).

## Operation
- States: IDLE, RUN, HOLD. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, the tuple is registered into a/b/c and the FSM moves to RUN.
- RUN:
  - The HLSM advances only while Start=1, so Start is held high for the whole run.
  - Completion pulse: done_fire = Done & ~done_q, where done_q is Done registered and resets to 1. A stale high Done from the previous run therefore never fires.
  - Start = (state==RUN) & ~done_fire. This is combinational, so Start is already low in the cycle Done rises and the HLSM does not relaunch from its idle state.
  - On done_fire: capture z→out_z and x→out_x, then move to HOLD.
- HOLD:
  - out_valid=1; out_z/out_x remain stable until out_ready=1.
  - On handshake, return to IDLE.
- in_ready=0 in RUN and HOLD. a/b/c change only at acceptance.
- Results pass through unmodified: no width conversion, no sign changes.
- Rst low at any time:
  - Immediately forces IDLE, Start=0, out_valid=0, done_q=1, timeout_err=0.
  - An in-flight job is discarded.

## Timing
- Reset values: in_ready=1 (after Rst release, state IDLE); Start=0, out_valid=0, busy=0, timeout_err=0; a, b, c, out_z, out_x = 0.
- Tuple accepted at edge E0 → Start=1 and busy=1 from the cycle after E0.
- Done first rises in cycle Tn → that cycle has Start=0, and z/x are captured at the end of Tn → out_valid=1 from Tn+1.
- Minimum accept-to-out_valid latency is HLSM run length + 1 cycle.
- out_valid with out_ready=1 in the same cycle → IDLE next cycle. There is no accept in that cycle, giving a minimum 1-cycle bubble between jobs.
- If Done is already 0 at launch, behaviour is identical: only a 0→1 transition completes a job.
- in_valid while busy is ignored; upstream must hold it until in_ready.

## Configuration
- HLSM_TIMEOUT_EN defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC with no done_fire: Start drops, the FSM returns to IDLE, no output is produced, and timeout_err is set.
  - timeout_err stays set until reset.
  - done_fire in the same cycle as the limit wins; the job completes normally.
- HLSM_TIMEOUT_EN undefined: no counter; timeout_err is tied to 0; RUN waits indefinitely.

## Test plan
- Reset with Rst=0 mid-RUN → Start=0, out_valid=0 and busy=0 immediately (asynchronous); state IDLE after release.
- in_a=5, in_b=7, in_c=2 with a model HLSM taking 12 cycles to raise Done (z=12, x=−3) → Start high exactly 12 cycles and low in the Done-rise cycle; out_valid 13 cycles after acceptance with out_z=12, out_x=−3.
- Same job with out_ready held 0 for 20 cycles → out_z/out_x stable, in_ready=0, and no relaunch (Start=0) throughout.
- Two back-to-back jobs where Done stays high between runs → the second launch does not complete early; second results are correct.
- With HLSM_TIMEOUT_EN and TIMEOUT_CYC=16, Done never rises → Start falls after 16 RUN cycles, timeout_err=1 (sticky), in_ready=1, no out_valid.
- Without the macro, the same stimulus → Start stays high indefinitely and timeout_err=0.

Source files
------------

// File: rtl/hlsm_dispatch.sv
// hlsm_dispatch: feeds one operand tuple at a time into the HLSM datapath,
// holds Start high for exactly one HLSM run, and returns the captured results
// on a valid/ready stream.
// Optional feature: define HLSM_TIMEOUT_EN to abort runs that exceed
// TIMEOUT_CYC cycles. When it is not defined, timeout_err is tied low.
//
// state | meaning
// IDLE  | ready for an operand tuple
// RUN   | Start held high, waiting for a Done rising edge
// HOLD  | results valid, waiting for downstream to take them
module hlsm_dispatch #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    output logic              Start,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    input  logic              Done,
    input  logic [DATA_W-1:0] z,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_z,
    output logic [DATA_W-1:0] out_x,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    logic   done_q;
    logic   done_fire;
    logic   limit_hit;

    // done_q resets high so a Done left high by the previous run never fires.
    assign done_fire = Done & ~done_q;

    // Start must already be low in the cycle Done rises, otherwise the HLSM
    // would relaunch from its idle state.
    assign Start = (state == RUN) & ~done_fire;

    // Registered copy of Done for rising-edge detection.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= Done;
        end
    end

`ifdef HLSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] run_cnt;

    // run_cnt holds (RUN cycles elapsed - 1); the last permitted cycle is the limit.
    assign limit_hit = (run_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Run-length counter and sticky abort flag.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            run_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                run_cnt <= '0;
            end else if (state == RUN) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (state == RUN && limit_hit && !done_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign limit_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Job sequencing: accept, run, present results.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            out_z     <= '0;
            out_x     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a        <= in_a;
                        b        <= in_b;
                        c        <= in_c;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // A completion in the limit cycle takes priority over the abort.
                    if (done_fire) begin
                        out_z     <= z;
                        out_x     <= x;
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end else if (limit_hit) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
